// File: rtl/video_timing_gen.sv
// Video raster timing and test-pattern generator.
// Counter stage -> pattern/sync stage -> output register stage, giving a
// fixed two-cycle latency from the raster counters to every output.
// Pattern slices go up to hcnt[10:3]/vcnt[10:3], so CW must be at least 11.
module video_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int DW       = 16,
  parameter int CW       = 12,
  parameter int BOX_X0   = 128,
  parameter int BOX_Y0   = 128,
  parameter int BOX_W    = 128,
  parameter int BOX_H    = 128
) (
  input  logic          sys2_clk,
  input  logic          sys2_rst,
  input  logic          run,
  input  logic [3:0]    mode,
  output logic          de,
  output logic          hs,
  output logic          vs,
  output logic [DW-1:0] data,
  output logic          sof,
  output logic [15:0]   frame_cnt
);

  // State table
  //   ST_IDLE  | counters held at (0,0), outputs idle, waiting for run
  //   ST_RUN   | raster counters advancing, frames repeat
  //   ST_DRAIN | run dropped; finish current frame then go idle
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0] BX_LO    = 32'(BOX_X0);
  localparam logic [31:0] BX_HI    = 32'(BOX_X0 + BOX_W);
  localparam logic [31:0] BY_LO    = 32'(BOX_Y0);
  localparam logic [31:0] BY_HI    = 32'(BOX_Y0 + BOX_H);

  localparam logic HS_ON  = (HS_POL != 0);
  localparam logic HS_OFF = ~HS_ON;
  localparam logic VS_ON  = (VS_POL != 0);
  localparam logic VS_OFF = ~VS_ON;

  localparam logic [DW-1:0] BLANK = (DW == 24) ? DW'(24'h101010) : DW'(16'h8010);

  logic          r_run_s1, r_run_s2;
  logic [3:0]    r_mode_s1, r_mode_s2;
  state_t        r_state;
  logic [CW-1:0] r_hcnt, r_vcnt;
  logic [3:0]    r_mode_q;
  logic [15:0]   r_frame_cnt;
  logic [2:0]    r_bar_idx;
  logic [CW-1:0] r_bar_rem;

  logic          r_p_de, r_p_hs, r_p_vs, r_p_sof;
  logic [7:0]    r_p_y;
  logic [15:0]   r_p_fcnt;

  logic [31:0]   w_h32, w_v32;
  logic          w_cnt_vld, w_h_last, w_v_last, w_frame_end;
  logic          w_active, w_hs_win, w_vs_win, w_in_box, w_origin;
  logic [7:0]    w_y;
  logic [DW-1:0] w_pix;

  assign w_h32       = 32'(r_hcnt);
  assign w_v32       = 32'(r_vcnt);
  assign w_cnt_vld   = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_h_last    = (w_h32 == 32'(H_TOTAL - 1));
  assign w_v_last    = (w_v32 == 32'(V_TOTAL - 1));
  assign w_frame_end = w_h_last && w_v_last;
  assign w_active    = (w_h32 < 32'(H_ACTIVE)) && (w_v32 < 32'(V_ACTIVE));
  assign w_hs_win    = (w_h32 >= HS_START) && (w_h32 < HS_END);
  assign w_vs_win    = (w_v32 >= VS_START) && (w_v32 < VS_END);
  assign w_in_box    = (w_h32 >= BX_LO) && (w_h32 < BX_HI) &&
                       (w_v32 >= BY_LO) && (w_v32 < BY_HI);
  assign w_origin    = (r_hcnt == '0) && (r_vcnt == '0);
  assign w_pix       = (DW == 24) ? DW'({r_p_y, r_p_y, r_p_y}) : DW'({8'h80, r_p_y});

  // Two-flop synchronisers for the asynchronous run/mode controls
  always_ff @(posedge sys2_clk or posedge sys2_rst) begin
    if (sys2_rst) begin
      r_run_s1  <= 1'b0;
      r_run_s2  <= 1'b0;
      r_mode_s1 <= '0;
      r_mode_s2 <= '0;
    end else begin
      r_run_s1  <= run;
      r_run_s2  <= r_run_s1;
      r_mode_s1 <= mode;
      r_mode_s2 <= r_mode_s1;
    end
  end

  // Run/drain FSM with raster counters; mode is latched only as a frame starts
  always_ff @(posedge sys2_clk or posedge sys2_rst) begin
    if (sys2_rst) begin
      r_state     <= ST_IDLE;
      r_hcnt      <= '0;
      r_vcnt      <= '0;
      r_mode_q    <= '0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_hcnt <= '0;
          r_vcnt <= '0;
          if (r_run_s2) begin
            r_state  <= ST_RUN;
            r_mode_q <= r_mode_s2;
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (w_frame_end) begin
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            if (r_run_s2) begin
              r_state  <= ST_RUN;
              r_mode_q <= r_mode_s2;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_state <= r_run_s2 ? ST_RUN : ST_DRAIN;
            if (w_h_last) begin
              r_hcnt <= '0;
              r_vcnt <= r_vcnt + CW'(1);
            end else begin
              r_hcnt <= r_hcnt + CW'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_hcnt  <= '0;
          r_vcnt  <= '0;
        end
      endcase
    end
  end

  // Luma bar tracker: down-counter per bar, the last bar absorbs the remainder
  always_ff @(posedge sys2_clk or posedge sys2_rst) begin
    if (sys2_rst) begin
      r_bar_idx <= '0;
      r_bar_rem <= CW'(BAR_W - 1);
    end else if (!w_cnt_vld || w_h_last) begin
      r_bar_idx <= '0;
      r_bar_rem <= CW'(BAR_W - 1);
    end else if (r_bar_rem == '0) begin
      if (r_bar_idx != 3'd7) begin
        r_bar_idx <= r_bar_idx + 3'd1;
        r_bar_rem <= CW'(BAR_W - 1);
      end
    end else begin
      r_bar_rem <= r_bar_rem - CW'(1);
    end
  end

  // Test-pattern luma selection for the current raster position
  always_comb begin
    w_y = 8'h10;
    case (r_mode_q)
      4'd0:    w_y = r_hcnt[7:0];
      4'd1:    w_y = r_vcnt[7:0];
      4'd2:    w_y = r_hcnt[8:1];
      4'd3:    w_y = r_vcnt[8:1];
      4'd4:    w_y = r_hcnt[9:2];
      4'd5:    w_y = r_vcnt[9:2];
      4'd6:    w_y = r_hcnt[10:3];
      4'd7:    w_y = r_vcnt[10:3];
      4'd8:    w_y = w_in_box ? r_vcnt[7:0] : r_hcnt[7:0];
      4'd9:    w_y = w_in_box ? r_frame_cnt[7:0] : r_hcnt[7:0];
      4'd10:   w_y = 8'h10 + {r_bar_idx, 5'b00000};
      4'd11:   w_y = (r_hcnt[6] ^ r_vcnt[6]) ? 8'hEB : 8'h10;
      default: w_y = 8'h10;
    endcase
  end

  // Pattern/sync stage: decode position into enables, syncs and luma
  always_ff @(posedge sys2_clk or posedge sys2_rst) begin
    if (sys2_rst) begin
      r_p_de   <= 1'b0;
      r_p_hs   <= HS_OFF;
      r_p_vs   <= VS_OFF;
      r_p_sof  <= 1'b0;
      r_p_y    <= 8'h10;
      r_p_fcnt <= '0;
    end else begin
      r_p_de   <= w_cnt_vld && w_active;
      r_p_hs   <= (w_cnt_vld && w_hs_win) ? HS_ON : HS_OFF;
      r_p_vs   <= (w_cnt_vld && w_vs_win) ? VS_ON : VS_OFF;
      r_p_sof  <= w_cnt_vld && w_origin;
      r_p_y    <= w_y;
      r_p_fcnt <= r_frame_cnt;
    end
  end

  // Output registers feeding the IOB flops; blanking data outside DE
  always_ff @(posedge sys2_clk or posedge sys2_rst) begin
    if (sys2_rst) begin
      de        <= 1'b0;
      hs        <= HS_OFF;
      vs        <= VS_OFF;
      sof       <= 1'b0;
      data      <= BLANK;
      frame_cnt <= '0;
    end else begin
      de        <= r_p_de;
      hs        <= r_p_hs;
      vs        <= r_p_vs;
      sof       <= r_p_sof;
      data      <= r_p_de ? w_pix : BLANK;
      frame_cnt <= r_p_fcnt;
    end
  end

endmodule
